// File: rtl/dc_ram_responder_pkg.sv
// Shared widths, request encoding and helpers for the RAM responder and its read pipeline.
package dc_ram_responder_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [1:0] {
    REQ_IDLE  = 2'b00,
    REQ_READ  = 2'b01,
    REQ_WRITE = 2'b10,
    REQ_BOTH  = 2'b11
  } req_kind_e;

  function automatic logic rd_latency_legal(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dc_ram_rd_pipe.sv
// Read-return shift register carrying {valid, data}; valid bits are cleared by a synchronous flush.
module dc_ram_rd_pipe
  import dc_ram_responder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic              valid_d;
      logic [DATA_W-1:0] data_d;
      logic              valid_q;
      logic [DATA_W-1:0] data_q;

      if (gi == 0) begin : g_head
        assign valid_d = in_valid;
        assign data_d  = in_data;
      end else begin : g_tail
        assign valid_d = g_stage[gi-1].valid_q;
        assign data_d  = g_stage[gi-1].data_q;
      end

      // Data is never reset: it only reaches the bus qualified by valid.
      always_ff @(posedge clk) begin
        if (flush) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= valid_d;
        end
        data_q <= data_d;
      end
    end
  endgenerate

  assign out_valid = g_stage[DEPTH-1].valid_q;
  assign out_data  = g_stage[DEPTH-1].data_q;

endmodule

// File: rtl/dc_ram_responder.sv
// RAM-side responder: 128-bit word store with pipelined reads onto a shared tri-state bus,
// sticky address/protocol error flags and saturating access counters.
module dc_ram_responder
  import dc_ram_responder_pkg::*;
#(
  parameter int                ADDR_BITS  = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int                RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_read_enable,
  input  logic              ram_write_enable,
  input  logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              rd_valid,
  output logic              addr_err,
  output logic              proto_err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
    $error("dc_ram_responder: RD_LATENCY must lie within 1..4");
  end

  // ---------------------------------------------------------------- decode
  logic [ADDR_W-1:0]    offs;
  logic                 in_range;
  logic [ADDR_BITS-1:0] idx;
  req_kind_e            req;

  assign offs     = addr - BASE_ADDR;
  assign in_range = (offs >> ADDR_BITS) == '0;
  assign idx      = offs[ADDR_BITS-1:0];

  always_comb begin
    req = REQ_IDLE;
    if (!reset) begin
      case ({ram_write_enable, ram_read_enable})
        2'b01:   req = REQ_READ;
        2'b10:   req = REQ_WRITE;
        2'b11:   req = REQ_BOTH;
        default: req = REQ_IDLE;
      endcase
    end
  end

  logic pipe_valid;
  logic rd_acc;
  logic wr_req;
  logic wr_acc;
  logic wr_conflict;
  logic addr_evt;
  logic proto_evt;

  // A write landing while read data is on the bus would sample our own drive.
  assign rd_acc      = (req == REQ_READ);
  assign wr_req      = (req == REQ_WRITE);
  assign wr_conflict = wr_req & pipe_valid;
  assign wr_acc      = wr_req & ~pipe_valid;
  assign addr_evt    = (rd_acc | wr_acc) & ~in_range;
  assign proto_evt   = (req == REQ_BOTH) | wr_conflict;

  // ---------------------------------------------------------------- array
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (wr_acc && in_range) begin
      mem[idx] <= data_bus;
    end
  end

  assign rd_word = in_range ? mem[idx] : '0;

  // ---------------------------------------------------------------- read return
  logic [DATA_W-1:0] pipe_data;

  dc_ram_rd_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (reset),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  assign data_bus = pipe_valid ? pipe_data : {DATA_W{1'bz}};
  assign rd_valid = pipe_valid;

  // ---------------------------------------------------------------- status
  logic              addr_err_q,  addr_err_d;
  logic              proto_err_q, proto_err_d;
  logic [ADDR_W-1:0] err_addr_q,  err_addr_d;
  logic [CNT_W-1:0]  rd_count_q,  rd_count_d;
  logic [CNT_W-1:0]  wr_count_q,  wr_count_d;

  always_comb begin
    addr_err_d  = addr_err_q;
    proto_err_d = proto_err_q;
    err_addr_d  = err_addr_q;
    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;

    if (rd_acc) begin
      rd_count_d = sat_inc(rd_count_q);
    end
    if (wr_acc && in_range) begin
      wr_count_d = sat_inc(wr_count_q);
    end
    // Only the first out-of-range address since reset is kept.
    if (addr_evt) begin
      addr_err_d = 1'b1;
      if (!addr_err_q) begin
        err_addr_d = addr;
      end
    end
    if (proto_evt) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_err_q  <= 1'b0;
      proto_err_q <= 1'b0;
      err_addr_q  <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      addr_err_q  <= addr_err_d;
      proto_err_q <= proto_err_d;
      err_addr_q  <= err_addr_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign addr_err  = addr_err_q;
  assign proto_err = proto_err_q;
  assign err_addr  = err_addr_q;
  assign rd_count  = rd_count_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_dc_ram_responder.sv
// Scoreboard bench for dc_ram_responder: directed scenarios plus random traffic against a behavioural memory model.
module tb_dc_ram_responder;

  localparam int          AB    = 10;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          LAT   = 2;
  localparam int          DEPTH = 1 << AB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         rd_en;
  logic         wr_en;
  logic [31:0]  addr;
  wire  [127:0] data_bus;
  logic [127:0] tb_bus;
  logic         tb_bus_en;
  logic         rd_valid;
  logic         addr_err;
  logic         proto_err;
  logic [31:0]  err_addr;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;

  assign data_bus = tb_bus_en ? tb_bus : {128{1'bz}};

  dc_ram_responder #(
    .ADDR_BITS  (AB),
    .BASE_ADDR  (BASE),
    .RD_LATENCY (LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ram_read_enable  (rd_en),
    .ram_write_enable (wr_en),
    .addr             (addr),
    .data_bus         (data_bus),
    .rd_valid         (rd_valid),
    .addr_err         (addr_err),
    .proto_err        (proto_err),
    .err_addr         (err_addr),
    .rd_count         (rd_count),
    .wr_count         (wr_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: expected read returns keyed by the cycle they must appear.
  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  bit           busy[int];
  logic [127:0] m_mem [DEPTH];
  logic [15:0]  m_rd;
  logic [15:0]  m_wr;
  bit           m_aerr;
  bit           m_perr;
  logic [31:0]  m_eaddr;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Monitor: one sample per cycle, after the edge and after the bench releases the bus.
  initial forever begin
    @(posedge clk);
    #2;
    if (mon_en) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        total++;
        if (rd_valid !== 1'b1 || data_bus !== sbq[0].data) begin
          bad++;
          $display("FAIL read_data cyc=%0d got valid=%b data=%h want valid=1 data=%h",
                   cyc, rd_valid, data_bus, sbq[0].data);
        end else begin
          $display("read  cyc=%0d data=%h", cyc, data_bus);
        end
        void'(sbq.pop_front());
      end else if (rd_valid !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid cyc=%0d got valid=%b want valid=0", cyc, rd_valid);
      end
      total++;
      if ({rd_count, wr_count, addr_err, proto_err, err_addr} !==
          {m_rd, m_wr, m_aerr, m_perr, m_eaddr}) begin
        bad++;
        $display("FAIL status cyc=%0d got rd=%0d wr=%0d aerr=%b perr=%b eaddr=%h want rd=%0d wr=%0d aerr=%b perr=%b eaddr=%h",
                 cyc, rd_count, wr_count, addr_err, proto_err, err_addr,
                 m_rd, m_wr, m_aerr, m_perr, m_eaddr);
      end
    end
  end

  function automatic void flag_addr(input logic [31:0] a);
    if (!m_aerr) m_eaddr = a;
    m_aerr = 1'b1;
  endfunction

  // One request per call: drive on the falling edge, release after the rising edge.
  task automatic do_op(input bit r, input bit w, input logic [31:0] a, input logic [127:0] d);
    logic [31:0] offs;
    bit          inr;
    bit          conflict;
    exp_t        e;
    @(negedge clk);
    offs     = a - BASE;
    inr      = offs < DEPTH;
    conflict = busy.exists(cyc);
    rd_en     = r;
    wr_en     = w;
    addr      = a;
    tb_bus    = d;
    tb_bus_en = w && !r && !conflict;
    if (r && w) begin
      m_perr = 1'b1;
    end else if (r) begin
      if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
      e.data = inr ? m_mem[offs[AB-1:0]] : 128'h0;
      e.due  = cyc + LAT;
      sbq.push_back(e);
      busy[cyc + LAT] = 1'b1;
      if (!inr) flag_addr(a);
    end else if (w) begin
      if (conflict) begin
        m_perr = 1'b1;
      end else if (inr) begin
        m_mem[offs[AB-1:0]] = d;
        if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
      end else begin
        flag_addr(a);
      end
    end
    @(posedge clk);
    #1;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    tb_bus_en = 1'b0;
  endtask

  // Reset edge, optionally with a read request presented alongside (which must be ignored).
  task automatic do_reset(input bit r, input logic [31:0] a);
    @(negedge clk);
    reset = 1'b1;
    rd_en = r;
    addr  = a;
    while (sbq.size() > 0 && sbq[sbq.size()-1].due > cyc) void'(sbq.pop_back());
    for (int k = cyc + 1; k <= cyc + LAT; k++) if (busy.exists(k)) busy.delete(k);
    m_rd = '0; m_wr = '0; m_aerr = 1'b0; m_perr = 1'b0; m_eaddr = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) do_op(1'b0, 1'b0, 32'h0, 128'h0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  int unsigned sel;
  logic [31:0] ra;

  initial begin
    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; tb_bus = '0; tb_bus_en = 1'b0;
    m_rd = '0; m_wr = '0; m_aerr = 1'b0; m_perr = 1'b0; m_eaddr = '0;
    repeat (3) @(posedge clk);
    do_reset(1'b0, 32'h0);
    mon_en = 1'b1;

    // Preload every word so every later read has a known model value.
    for (int i = 0; i < DEPTH; i++) do_op(1'b0, 1'b1, BASE + i, rnd128());
    do_reset(1'b0, 32'h0);

    // Simple write then read.
    do_op(1'b0, 1'b1, BASE + 5, {16{8'hA5}});
    do_op(1'b1, 1'b0, BASE + 5, 128'h0);
    idle(LAT + 1);

    // Back-to-back reads in reverse order.
    for (int i = 0; i < 4; i++) do_op(1'b0, 1'b1, BASE + i, 128'(i));
    for (int i = 3; i >= 0; i--) do_op(1'b1, 1'b0, BASE + i, 128'h0);
    idle(LAT + 1);

    // Both enables together: nothing happens except the protocol flag.
    do_op(1'b0, 1'b1, BASE + 7, 128'h7777_0000_1111_2222_3333_4444_5555_6666);
    do_op(1'b1, 1'b1, BASE + 7, 128'hDEAD_BEEF);
    do_op(1'b1, 1'b0, BASE + 7, 128'h0);
    idle(LAT + 1);

    // Out-of-range read, then a second out-of-range write that must not move err_addr.
    do_op(1'b1, 1'b0, BASE + 32'h400, 128'h0);
    do_op(1'b0, 1'b1, BASE + 32'h500, rnd128());
    idle(LAT + 1);

    // Reset while reads are in flight.
    do_reset(1'b0, 32'h0);
    do_op(1'b0, 1'b1, BASE + 1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    do_op(1'b1, 1'b0, BASE + 1, 128'h0);
    do_reset(1'b1, BASE + 2);
    idle(LAT + 2);
    do_op(1'b1, 1'b0, BASE + 1, 128'h0);
    idle(LAT + 1);

    // Write that collides with read data on the bus is dropped.
    do_op(1'b1, 1'b0, BASE + 9, 128'h0);
    idle(LAT - 1);
    do_op(1'b0, 1'b1, BASE + 10, 128'h0);
    do_op(1'b1, 1'b0, BASE + 10, 128'h0);
    idle(LAT + 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) ra = BASE + DEPTH + $urandom_range(0, 4095);
      else                            ra = BASE + $urandom_range(0, DEPTH - 1);
      if (sel < 45)      do_op(1'b1, 1'b0, ra, 128'h0);
      else if (sel < 80) do_op(1'b0, 1'b1, ra, rnd128());
      else if (sel < 94) idle(1);
      else if (sel < 98) do_op(1'b1, 1'b1, ra, rnd128());
      else               do_reset(1'b0, 32'h0);
    end
    idle(LAT + 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
